// File: rtl/calc_engine_if.sv
// Button/operand inputs and display-side outputs of the calculator core.
// The master side drives pulses and the operand; the slave side is calc_engine.
interface calc_engine_if #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned NUM_REGS = 4
);
  localparam int unsigned RSW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic                    btn_up;
  logic                    btn_down;
  logic                    btn_left;
  logic                    btn_right;
  logic                    btn_sel;
  logic signed [WIDTH-1:0] operand;
  logic [1:0]              mode;
  logic [1:0]              op;
  logic [RSW-1:0]          reg_sel;
  logic signed [WIDTH-1:0] acc_value;
  logic                    overflow;
  logic                    busy;
  logic                    done;

  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_sel, operand,
    input  mode, op, reg_sel, acc_value, overflow, busy, done
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_sel, operand,
    output mode, op, reg_sel, acc_value, overflow, busy, done
  );
endinterface

// File: rtl/calc_engine.sv
// Calculator arithmetic core: mode FSM, NUM_REGS-deep signed register bank, multi-cycle divider.
// Optional build macro CALC_SAT_EN: overflowing results saturate instead of wrapping.
module calc_engine #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned NUM_REGS = 4
) (
  input  logic         clk,
  input  logic         rst,
  calc_engine_if.slave bus
);
  localparam int unsigned RSW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned W2  = 2 * WIDTH;
  localparam int unsigned CW  = $clog2(WIDTH + 2);
  localparam logic [CW-1:0]  CNT_WR  = CW'(WIDTH + 1);
  localparam logic [RSW-1:0] SEL_TOP = RSW'(NUM_REGS - 1);
  localparam logic signed [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EDIT   = 2'd1,
    ST_MEMORY = 2'd2,
    ST_EXEC   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_t;

  state_t                  state_q, state_d;
  op_t                     op_q, op_d;
  logic [RSW-1:0]          reg_sel_q, reg_sel_d;
  logic signed [WIDTH-1:0] regs_q [NUM_REGS];
  logic signed [WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]     flags_q, flags_d;
  logic signed [WIDTH-1:0] opnd_q, opnd_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [WIDTH-1:0]        rem_q, rem_d;
  logic [WIDTH-1:0]        quo_q, quo_d;
  logic [WIDTH-1:0]        dvs_q, dvs_d;
  logic                    neg_q, neg_d;
  logic signed [WIDTH-1:0] acc_q, acc_d;
  logic                    ovf_q, ovf_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic signed [WIDTH-1:0] cur;
  logic signed [W2-1:0]    true_v;
  logic signed [WIDTH-1:0] wr_val;
  logic                    wr_ovf;
  logic [WIDTH:0]          div_sh;

  // Exact result of the pending operation and its write-back value/flag
  always_comb begin
    cur    = regs_q[reg_sel_q];
    true_v = '0;
    unique case (op_q)
      OP_ADD: true_v = W2'(cur) + W2'(opnd_q);
      OP_SUB: true_v = W2'(cur) - W2'(opnd_q);
      OP_MUL: true_v = W2'(cur) * W2'(opnd_q);
      OP_DIV: true_v = neg_q ? -W2'(quo_q) : W2'(quo_q);
    endcase
    // Fits in WIDTH bits only when all bits from the WIDTH-1 sign position upward agree
    wr_ovf = ~((&true_v[W2-1:WIDTH-1]) | ~(|true_v[W2-1:WIDTH-1]));
`ifdef CALC_SAT_EN
    wr_val = wr_ovf ? (true_v[W2-1] ? SMIN : SMAX) : true_v[WIDTH-1:0];
`else
    wr_val = true_v[WIDTH-1:0];
`endif
    if (op_q == OP_DIV && opnd_q == '0) begin
      wr_val = cur;
      wr_ovf = 1'b1;
    end
  end

  // Mode FSM, register bank updates and divider sequencing
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    reg_sel_d = reg_sel_q;
    regs_d    = regs_q;
    flags_d   = flags_q;
    opnd_d    = opnd_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_d     = neg_q;
    done_d    = 1'b0;
    div_sh    = {rem_q, quo_q[WIDTH-1]};

    unique case (state_q)
      ST_IDLE: begin
        if (bus.btn_sel) begin
          state_d = ST_MEMORY;
        end else if (bus.btn_right) begin
          state_d = ST_EDIT;
          op_d    = OP_ADD;
        end else if (bus.btn_left) begin
          state_d = ST_EDIT;
          op_d    = OP_SUB;
        end else if (bus.btn_up) begin
          state_d = ST_EDIT;
          op_d    = OP_MUL;
        end else if (bus.btn_down) begin
          state_d = ST_EDIT;
          op_d    = OP_DIV;
        end
      end

      ST_EDIT: begin
        if (bus.btn_sel) begin
          opnd_d  = bus.operand;
          cnt_d   = '0;
          state_d = ST_EXEC;
        end
      end

      ST_MEMORY: begin
        if (bus.btn_sel) begin
          state_d = ST_IDLE;
        end else if (bus.btn_right) begin
          reg_sel_d = (reg_sel_q == SEL_TOP) ? '0 : reg_sel_q + RSW'(1);
        end else if (bus.btn_left) begin
          reg_sel_d = (reg_sel_q == '0) ? SEL_TOP : reg_sel_q - RSW'(1);
        end else if (bus.btn_up) begin
          state_d = ST_MEMORY;
        end else if (bus.btn_down) begin
          regs_d[reg_sel_q]  = '0;
          flags_d[reg_sel_q] = 1'b0;
        end
      end

      ST_EXEC: begin
        cnt_d = cnt_q + CW'(1);
        if (op_q != OP_DIV) begin
          if (cnt_q == CW'(1)) begin
            regs_d[reg_sel_q]  = wr_val;
            flags_d[reg_sel_q] = wr_ovf;
            done_d             = 1'b1;
            state_d            = ST_IDLE;
          end
        end else if (cnt_q == '0) begin
          // Divider works on magnitudes; MIN maps to 2^(WIDTH-1) which still fits unsigned
          rem_d = '0;
          quo_d = cur[WIDTH-1] ? WIDTH'(-cur) : WIDTH'(cur);
          dvs_d = opnd_q[WIDTH-1] ? WIDTH'(-opnd_q) : WIDTH'(opnd_q);
          neg_d = cur[WIDTH-1] ^ opnd_q[WIDTH-1];
        end else if (cnt_q != CNT_WR) begin
          if (div_sh >= {1'b0, dvs_q}) begin
            rem_d = WIDTH'(div_sh - {1'b0, dvs_q});
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = div_sh[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          regs_d[reg_sel_q]  = wr_val;
          flags_d[reg_sel_q] = wr_ovf;
          done_d             = 1'b1;
          state_d            = ST_IDLE;
        end
      end
    endcase

    acc_d  = regs_d[reg_sel_d];
    ovf_d  = flags_d[reg_sel_d];
    busy_d = (state_d == ST_EXEC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_ADD;
      reg_sel_q <= '0;
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
      flags_q   <= '0;
      opnd_q    <= '0;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_q     <= 1'b0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      reg_sel_q <= reg_sel_d;
      regs_q    <= regs_d;
      flags_q   <= flags_d;
      opnd_q    <= opnd_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_q     <= neg_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.mode      = state_q;
  assign bus.op        = op_q;
  assign bus.reg_sel   = reg_sel_q;
  assign bus.acc_value = acc_q;
  assign bus.overflow  = ovf_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_calc_engine.sv
// Directed self-checking bench for calc_engine (WIDTH=16, NUM_REGS=4).
module tb_calc_engine;
  localparam int unsigned WIDTH    = 16;
  localparam int unsigned NUM_REGS = 4;

`ifdef CALC_SAT_EN
  localparam int EXP_MUL_A  = 32767;
  localparam int EXP_MUL_B  = 32767;
  localparam int EXP_MINDIV = 32767;
`else
  localparam int EXP_MUL_A  = -15536;
  localparam int EXP_MUL_B  = 7856;
  localparam int EXP_MINDIV = -32768;
`endif

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  calc_engine_if #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS)) bus ();

  calc_engine #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Mask order: {sel, right, left, up, down}
  task automatic set_btns(input logic [4:0] m);
    {bus.btn_sel, bus.btn_right, bus.btn_left, bus.btn_up, bus.btn_down} = m;
  endtask

  task automatic press(input logic [4:0] m);
    set_btns(m);
    tick();
    set_btns(5'b00000);
  endtask

  task automatic enter_op(input string tag, input logic [4:0] m, input int exp_op);
    press(m);
    check({tag, "_mode"}, 32'(bus.mode), 1);
    check({tag, "_op"}, 32'(bus.op), exp_op);
  endtask

  task automatic exec_op(input string tag, input logic signed [15:0] opv, input int exp_lat,
                         input int exp_acc, input int exp_ovf, input bit hammer);
    logic signed [15:0] pre;
    int n;
    bit busy_ok;
    bit pre_ok;
    pre = bus.acc_value;
    bus.operand = opv;
    press(5'b10000);
    n = 0;
    busy_ok = 1'b1;
    pre_ok = 1'b1;
    while (bus.done !== 1'b1 && n < 40) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (bus.acc_value !== pre) pre_ok = 1'b0;
      set_btns((hammer && n >= 2 && n <= 5) ? 5'b11111 : 5'b00000);
      tick();
      n++;
    end
    set_btns(5'b00000);
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_busy_held"}, 32'(busy_ok), 1);
    check({tag, "_acc_pre"}, 32'(pre_ok), 1);
    check({tag, "_mode_idle"}, 32'(bus.mode), 0);
    check({tag, "_busy_low"}, 32'(bus.busy), 0);
    check({tag, "_acc"}, bus.acc_value, exp_acc);
    check({tag, "_ovf"}, 32'(bus.overflow), exp_ovf);
    tick();
    check({tag, "_done_pulse"}, 32'(bus.done), 0);
  endtask

  task automatic clear_r0();
    press(5'b10000);
    press(5'b00001);
    check("clr_acc", bus.acc_value, 0);
    check("clr_ovf", 32'(bus.overflow), 0);
    press(5'b10000);
  endtask

  initial begin
    bit seen_done;
    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    bus.operand = '0;
    set_btns(5'b00000);
    tick();
    tick();
    rst = 1'b0;

    check("rst_mode", 32'(bus.mode), 0);
    check("rst_op", 32'(bus.op), 0);
    check("rst_sel", 32'(bus.reg_sel), 0);
    check("rst_acc", bus.acc_value, 0);
    check("rst_ovf", 32'(bus.overflow), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);

    enter_op("add5", 5'b01000, 0);
    exec_op("add5", 16'sd5, 2, 5, 0, 1'b0);

    enter_op("mul10k", 5'b00010, 2);
    exec_op("mul10k", 16'sd10000, 2, EXP_MUL_A, 1, 1'b0);

    clear_r0();
    enter_op("add100", 5'b01000, 0);
    exec_op("add100", 16'sd100, 2, 100, 0, 1'b0);

    enter_op("divm7", 5'b00001, 3);
    exec_op("divm7", -16'sd7, 18, -14, 0, 1'b0);

    enter_op("div0", 5'b00001, 3);
    exec_op("div0", 16'sd0, 18, -14, 1, 1'b1);
    check("div0_sel_kept", 32'(bus.reg_sel), 0);
    check("div0_op_kept", 32'(bus.op), 3);

    enter_op("prio_sub", 5'b00110, 1);
    exec_op("sub6", 16'sd6, 2, -20, 0, 1'b0);
    enter_op("prio_mul", 5'b00011, 2);
    exec_op("mulm3", -16'sd3, 2, 60, 0, 1'b0);

    press(5'b11000);
    check("idle_sel_right_mode", 32'(bus.mode), 2);
    check("idle_sel_right_sel", 32'(bus.reg_sel), 0);
    for (int i = 1; i <= 4; i++) begin
      press(5'b01000);
      check($sformatf("mem_right%0d", i), 32'(bus.reg_sel), i % 4);
    end
    press(5'b00100);
    check("mem_left_wrap", 32'(bus.reg_sel), 3);
    check("mem_r3_acc", bus.acc_value, 0);
    press(5'b10000);
    check("mem_exit_mode", 32'(bus.mode), 0);
    check("mem_exit_sel", 32'(bus.reg_sel), 3);

    enter_op("r3add9", 5'b01000, 0);
    exec_op("r3add9", 16'sd9, 2, 9, 0, 1'b0);
    enter_op("r3mul", 5'b00010, 2);
    exec_op("r3mul", 16'sd30000, 2, EXP_MUL_B, 1, 1'b0);

    press(5'b10000);
    press(5'b00010);
    check("mem_up_mode", 32'(bus.mode), 2);
    check("mem_up_acc", bus.acc_value, EXP_MUL_B);
    press(5'b00001);
    check("mem_clr_r3_acc", bus.acc_value, 0);
    check("mem_clr_r3_ovf", 32'(bus.overflow), 0);
    press(5'b11000);
    check("mem_sel_right_mode", 32'(bus.mode), 0);
    check("mem_sel_right_sel", 32'(bus.reg_sel), 3);

    press(5'b10000);
    press(5'b01000);
    check("r0_back_sel", 32'(bus.reg_sel), 0);
    check("r0_back_acc", bus.acc_value, 60);
    press(5'b10000);

    clear_r0();
    enter_op("addmin", 5'b01000, 0);
    exec_op("addmin", -16'sd32768, 2, -32768, 0, 1'b0);
    enter_op("mindiv", 5'b00001, 3);
    exec_op("mindiv", -16'sd1, 18, EXP_MINDIV, 1, 1'b0);

    clear_r0();
    enter_op("abort_add", 5'b01000, 0);
    exec_op("abort_add", 16'sd100, 2, 100, 0, 1'b0);
    enter_op("abort_div", 5'b00001, 3);
    bus.operand = 16'sd3;
    press(5'b10000);
    check("abort_busy", 32'(bus.busy), 1);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_mode", 32'(bus.mode), 0);
    check("abort_busy_low", 32'(bus.busy), 0);
    check("abort_done", 32'(bus.done), 0);
    check("abort_acc", bus.acc_value, 0);
    check("abort_ovf", 32'(bus.overflow), 0);
    seen_done = 1'b0;
    repeat (20) begin
      tick();
      if (bus.done === 1'b1) seen_done = 1'b1;
    end
    check("abort_no_done", 32'(seen_done), 0);
    press(5'b10000);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("abort_reg%0d", i), bus.acc_value, 0);
      press(5'b01000);
    end
    press(5'b10000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/calc_engine.md
Name: calc_engine

Overview:
Parametrised arithmetic/register core for the FPGA calculator. It replaces the fixed 16-bit, 4-register mode logic with a WIDTH-bit, NUM_REGS-deep register bank and a mode FSM. Division is multi-cycle with a busy/done handshake. It sits between the edge-detected button pulses and the display/digit-edit logic; it consumes the edited operand and drives the selected register value and overflow flag.

Parameters:
WIDTH, 16, signed data width of the operand and registers (min 4)
NUM_REGS, 4, number of result registers (min 2); RSW = max(1, $clog2(NUM_REGS))

Ports:
clk  in  1  system clock (display-rate tick domain)
rst  in  1  synchronous, active-high reset
btn_up  in  1  single-cycle pulse: multiply / unused
btn_down  in  1  single-cycle pulse: divide / clear register
btn_left  in  1  single-cycle pulse: subtract / previous register
btn_right  in  1  single-cycle pulse: add / next register
btn_sel  in  1  single-cycle pulse: select/commit
operand  in  WIDTH  signed operand from the digit editor
mode  out  2  0=IDLE, 1=EDIT, 2=MEMORY, 3=EXEC
op  out  2  0=add, 1=sub, 2=mul, 3=div
reg_sel  out  RSW  selected register index
acc_value  out  WIDTH  contents of register reg_sel (signed)
overflow  out  1  overflow flag of register reg_sel
busy  out  1  high while mode==EXEC
done  out  1  one-cycle pulse: result written

Behaviour:
- Reset (synchronous, active-high on clk): mode=IDLE, op=0, reg_sel=0, all registers and flags 0, busy=0, done=0. Reset during EXEC aborts the operation; no write occurs.
- Button priority when multiple pulses arrive in the same cycle: sel > right > left > up > down. Only the highest-priority pulse acts.
- IDLE:
  - right/left/up/down -> EDIT with op=0/1/2/3.
  - sel -> MEMORY.
- EDIT:
  - sel latches operand and moves to EXEC.
  - Direction pulses are ignored by this block; the digit editor consumes them.
- MEMORY:
  - right: reg_sel+1, wrapping NUM_REGS-1 -> 0.
  - left: reg_sel-1, wrapping 0 -> NUM_REGS-1.
  - down: clears the selected register and its flag to 0.
  - up: ignored.
  - sel -> IDLE.
- EXEC: computes R[reg_sel] op latched_operand. All buttons are ignored while busy.
  - add/sub/mul: the register is written on the 2nd clock edge after the sel edge. done pulses in the cycle the new value is visible. mode returns to IDLE on that same edge.
  - div: unsigned restoring divider on magnitudes, WIDTH iterations. The result is visible, with done, on the (WIDTH+2)th edge after sel. Quotient truncates toward zero; sign = XOR of operand signs.
- Arithmetic: signed two's complement. Products use a 2*WIDTH intermediate.
  - Overflow: result is outside [-2^(WIDTH-1), 2^(WIDTH-1)-1]. This includes MIN / -1.
  - The destination flag is updated on every write: 1 on overflow, else 0.
- Divide by zero: register value unchanged, flag=1, normal done timing.
- acc_value and overflow show the pre-operation value throughout EXEC.

Optional Feature:
CALC_SAT_EN
- Defined: an overflowing result saturates to 2^(WIDTH-1)-1 (positive true result) or -2^(WIDTH-1) (negative true result).
- Undefined: an overflowing result wraps, keeping the low WIDTH bits of the true result.
- The overflow flag behaves identically in both builds.

Test Plan:
- WIDTH=16, after reset: right, operand=5, sel -> done 2 cycles after sel; acc_value=5, overflow=0, mode=IDLE.
- reg0=5: up, operand=10000, sel -> overflow=1. With CALC_SAT_EN acc_value=32767; without, acc_value=-15536 (50000 truncated).
- reg0=100: down, operand=-7, sel -> busy high for 17 cycles; done on edge 18; acc_value=-14, overflow=0.
- reg0=-14: down, operand=0, sel -> acc_value stays -14, overflow=1. Buttons pulsed during busy have no effect.
- MEMORY: sel, then right x4 -> reg_sel 1,2,3,0. Then left -> 3. Then down -> R3=0, flag 0. Then sel -> IDLE. Simultaneous sel+right in MEMORY -> IDLE, reg_sel unchanged.
- reg0=100 dividing by 3: assert rst 5 cycles after sel -> next cycle mode=IDLE, busy=0, all registers 0, no done pulse.
